adc_axil_slave: RTL
===================

Name: adc_axil_slave

Overview:
AXI4-Lite responder (slave) for the ADC IP S00_AXI port. Terminates single-beat transactions from the PS/VIP master and holds four 32-bit registers. Register contents drive the ADC control fabric. Optional capture of live ADC samples into register 3.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
reg0_o..reg3_o  out  32 each  current register values
adc_data_i  in  32  ADC sample; used only with the optional feature
adc_valid_i  in  1  sample strobe; used only with the optional feature

Behaviour:
- Reset (asynchronous, S_AXI_ARESETN=0): all READY/VALID outputs 0; RDATA=0; registers 0; internal AW/W latches cleared. An in-flight transaction is abandoned with no response.
- Write path, states W_IDLE / W_RESP:
  - W_IDLE: AWREADY=1 while no AW is latched; WREADY=1 while no W is latched. AW and W are accepted independently, in either order or in the same cycle.
  - Commit: in the cycle both are latched, or both handshake together, the register write commits at the next clock edge. Each byte lane is written only where WSTRB is set. Then go to W_RESP.
  - W_RESP: BVALID=1 and held until BREADY; AWREADY=WREADY=0. On BVALID&BREADY, clear the latches and return to W_IDLE.
  - Minimum write latency: AW+W handshake at edge N, register updated and BVALID=1 after edge N+1.
- Read path, states R_IDLE / R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, RDATA is captured from the register selected by ARADDR[3:2] and RVALID=1 in the next cycle.
  - R_DATA: ARREADY=0. RVALID and RDATA are held stable until RREADY; then return to R_IDLE.
  - Read latency is 1 cycle. Back-to-back reads therefore take 2 cycles each.
- Read and write paths run concurrently. If a read captures the same register in the same cycle a write commits, the read returns the pre-write value.
- Only one outstanding transaction per direction.
- BRESP and RRESP are always OKAY.
- reg*_o change only on a write commit, or through the optional capture.

Optional Feature:
ADC_SAMPLE_CAPTURE_EN
- Defined:
  - reg3 is read-only; writes to offset 0xC still complete with OKAY but change nothing.
  - On each cycle adc_valid_i=1, reg3 loads adc_data_i, visible on reg3_o the next cycle.
  - A read capturing reg3 in the same cycle as a sample load returns the old value.
- Undefined: reg3 is read/write like reg0–2; adc_data_i and adc_valid_i are unused.

Decomposition:
- Package adc_axil_pkg:
  - register offset constants REG_CTRL=0x0, REG_CFG=0x4, REG_AUX=0x8, REG_SAMPLE=0xC;
  - RESP_OKAY=2'b00;
  - enums wr_state_t and rd_state_t.
- Sub-module adc_axil_regfile: 4×32 register array with byte-strobe write port, one combinational read port, and the optional capture port. The handshake FSMs stay in the top module.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to offsets 0x0,0x4,0x8,0xC, then read the same offsets -> read data 0x1..0x4, all responses OKAY, no stalls.
- AWVALID asserted 3 cycles before WVALID (data 0xA5A5A5A5 to offset 0x4) -> AWREADY drops after the AW handshake; reg1 updates only after W is accepted; BVALID follows 1 cycle later.
- reg0=0x11223344, then write 0xFFFFFFFF to offset 0x0 with WSTRB=4'b0101 -> reg0 reads 0x11FF33FF.
- BREADY held low for 5 cycles after a write -> BVALID stays 1 and AWREADY/WREADY stay 0; the next write is accepted only after BREADY.
- Read offset 0x8 issued in the same cycle that a write of 0x55 to 0x8 commits (old value 0x3) -> RDATA=0x3; a following read returns 0x55.
- Reset asserted while BVALID=1 -> BVALID, RVALID, AWREADY and ARREADY go 0 immediately and registers read 0 after reset. With ADC_SAMPLE_CAPTURE_EN: adc_valid_i pulse with 0xDEAD -> reading 0xC returns 0xDEAD, and a write to 0xC is ignored.

Source files
------------

// File: rtl/adc_axil_pkg.sv
// Shared constants and state types for the ADC AXI4-Lite register slave.
package adc_axil_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_CFG    = 4'h4;
    localparam logic [3:0] REG_AUX    = 4'h8;
    localparam logic [3:0] REG_SAMPLE = 4'hC;

    // Word index of the sample register within the 4-entry array.
    localparam logic [1:0] IDX_SAMPLE = REG_SAMPLE[3:2];

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/adc_axil_regfile.sv
// 4x32 register array: byte-strobed write port, combinational read port.
// With ADC_SAMPLE_CAPTURE_EN defined, word 3 becomes a read-only ADC sample capture.
module adc_axil_regfile
    import adc_axil_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_idx_i,
    input  logic [31:0]      wr_data_i,
    input  logic [3:0]       wr_strb_i,
    input  logic [1:0]       rd_idx_i,
    output logic [31:0]      rd_data_o,
    input  logic [31:0]      adc_data_i,
    input  logic             adc_valid_i,
    output logic [3:0][31:0] regs_o
);

    logic [3:0][31:0] regs_q;
    logic             wr_allowed;

`ifdef ADC_SAMPLE_CAPTURE_EN
    // Bus writes to the sample word are acknowledged but dropped.
    assign wr_allowed = (wr_idx_i != IDX_SAMPLE);
`else
    assign wr_allowed = 1'b1;
    logic unused_adc;
    assign unused_adc = ^{adc_data_i, adc_valid_i};
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '0;
        end else begin
            if (wr_en_i && wr_allowed) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb_i[b]) begin
                        regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                    end
                end
            end
`ifdef ADC_SAMPLE_CAPTURE_EN
            if (adc_valid_i) begin
                regs_q[IDX_SAMPLE] <= adc_data_i;
            end
`endif
        end
    end

    assign rd_data_o = regs_q[rd_idx_i];
    assign regs_o    = regs_q;

endmodule

// File: rtl/adc_axil_slave.sv
// AXI4-Lite slave for the ADC S00_AXI port: independent write and read FSMs over a 4-word regfile.
// Optional ADC_SAMPLE_CAPTURE_EN turns register 3 into a live ADC sample capture.
module adc_axil_slave
    import adc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     reg0_o,
    output logic [31:0]                     reg1_o,
    output logic [31:0]                     reg2_o,
    output logic [31:0]                     reg3_o,
    input  logic [31:0]                     adc_data_i,
    input  logic                            adc_valid_i
);

    wr_state_t        wr_state_q;
    logic             aw_lat_q, w_lat_q;
    logic             awready_q, wready_q, bvalid_q;
    logic [1:0]       aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    rd_state_t        rd_state_q;
    logic             arready_q, rvalid_q;
    logic [31:0]      rdata_q;

    logic             aw_hs, w_hs, ar_hs, wr_commit;
    logic [31:0]      rd_data;
    logic [3:0][31:0] regs;

    assign aw_hs     = S_AXI_AWVALID && awready_q;
    assign w_hs      = S_AXI_WVALID && wready_q;
    assign ar_hs     = S_AXI_ARVALID && arready_q;
    // The write always commits from the latches, one edge after the later of the two handshakes.
    assign wr_commit = (wr_state_q == W_IDLE) && aw_lat_q && w_lat_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= W_IDLE;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_commit) begin
                        wr_state_q <= W_RESP;
                        bvalid_q   <= 1'b1;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_lat_q <= 1'b1;
                            aw_idx_q <= S_AXI_AWADDR[3:2];
                        end
                        if (w_hs) begin
                            w_lat_q <= 1'b1;
                            wdata_q <= S_AXI_WDATA[31:0];
                            wstrb_q <= S_AXI_WSTRB[3:0];
                        end
                        awready_q <= !(aw_lat_q || aw_hs);
                        wready_q  <= !(w_lat_q || w_hs);
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        aw_lat_q   <= 1'b0;
                        w_lat_q    <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= R_DATA;
                        rdata_q    <= rd_data;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    adc_axil_regfile u_regfile (
        .clk_i       (S_AXI_ACLK),
        .rst_n_i     (S_AXI_ARESETN),
        .wr_en_i     (wr_commit),
        .wr_idx_i    (aw_idx_q),
        .wr_data_i   (wdata_q),
        .wr_strb_i   (wstrb_q),
        .rd_idx_i    (S_AXI_ARADDR[3:2]),
        .rd_data_o   (rd_data),
        .adc_data_i  (adc_data_i),
        .adc_valid_i (adc_valid_i),
        .regs_o      (regs)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];

    logic unused_in;
    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
